// File: rtl/btn_conditioner.sv
// btn_conditioner
// Turns one raw, bouncy, asynchronous push-button pin into a clean debounced
// level plus single-cycle press/release events and a wrapping press counter.
//
// Signal flow: btn_in -> 2-FF synchroniser -> polarity fix (raw, 1 = pressed)
// -> four-state debounce FSM -> registered outputs.
//
// Optional feature: define BTN_LONG_PRESS_EN to build the hold counter that
// raises long_pulse once per press held for LONG_CYCLES cycles. Without the
// macro the hold counter is not built and long_pulse is tied low.
//
// There are no valid/ready handshakes here: every output is a plain
// registered level or a one-cycle strobe.
//
// For checker binding, the FSM state is the internal signal 'state'
// (type state_t), and the debounce counter is 'cnt'.

`timescale 1ns/1ps

module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned LONG_CYCLES     = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic [7:0] press_cnt,
   output logic       long_pulse
);

   // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Pin value while the key is not pressed.
   localparam logic PIN_IDLE = ACTIVE_LOW;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic sync_meta;
   logic sync_q;
   logic raw;

`ifdef BTN_LONG_PRESS_EN
   // Hold counter saturates at LONG_CYCLES-1; long_pulse fires on the edge
   // that brings it there, so exactly one pulse per press.
   localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

   logic [HOLD_W-1:0] hold_cnt;
`else
   // Hold detection not built; the parameter is kept only for a uniform
   // instantiation interface.
   localparam int unsigned long_cycles_unused = LONG_CYCLES;

   assign long_pulse = 1'b0;
`endif

   // Two-flop synchroniser; reset parks both flops at the idle pin value so
   // a key held through reset is seen as a fresh press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta <= PIN_IDLE;
         sync_q    <= PIN_IDLE;
      end else begin
         sync_meta <= btn_in;
         sync_q    <= sync_meta;
      end
   end

   // Normalise polarity: raw is 1 whenever the key is physically pressed.
   assign raw = sync_q ^ ACTIVE_LOW;

   // Debounce FSM with all outputs registered; strobes default low each cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= RELEASED;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         press_cnt     <= 8'd0;
`ifdef BTN_LONG_PRESS_EN
         long_pulse    <= 1'b0;
         hold_cnt      <= '0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
         long_pulse    <= 1'b0;

         // Count hold time while the accepted level is pressed, including
         // release bounces; stop once the long press has been reported.
         if ((state == PRESSED || state == RELEASE_PEND) && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_PRE) begin
               long_pulse <= 1'b1;
            end
         end
`endif

         case (state)
            RELEASED: begin
               if (raw) begin
                  state <= PRESS_PEND;
                  cnt   <= '0;
               end
            end

            PRESS_PEND: begin
               if (!raw) begin
                  // Too short: treat as a glitch and forget it.
                  state <= RELEASED;
               end else if (cnt == CNT_LAST) begin
                  state       <= PRESSED;
                  btn_level   <= 1'b1;
                  press_pulse <= 1'b1;
                  press_cnt   <= press_cnt + 8'd1;
`ifdef BTN_LONG_PRESS_EN
                  hold_cnt    <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PRESSED: begin
               if (!raw) begin
                  state <= RELEASE_PEND;
                  cnt   <= '0;
               end
            end

            RELEASE_PEND: begin
               if (raw) begin
                  // Release bounce: back to pressed, hold time keeps running.
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state         <= RELEASED;
                  btn_level     <= 1'b0;
                  release_pulse <= 1'b1;
`ifdef BTN_LONG_PRESS_EN
                  hold_cnt      <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, LONG_CYCLES=20).
// Expected outputs come from a run-length reference model: the pin reaches the
// debouncer two edges late, and the accepted level flips once the delayed
// pin has disagreed with it for DEBOUNCE_CYCLES+1 consecutive edges.

`timescale 1ns/1ps

module tb_btn_conditioner;

  localparam int unsigned DEB     = 4;
  localparam bit          ACT_LOW = 1'b1;
  localparam int unsigned LONG    = 20;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  localparam logic PIN_UP = ACT_LOW;
  localparam logic PIN_DN = !ACT_LOW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic btn_in;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_cnt;
  logic       long_pulse;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (ACT_LOW),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_cnt    (press_cnt),
    .long_pulse   (long_pulse)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit         hist[$] = '{1'b0, 1'b0};
  bit         m_raw;
  int         run = 0;
  logic       e_level = 1'b0;
  logic       e_press = 1'b0;
  logic       e_rel = 1'b0;
  logic       e_long = 1'b0;
  logic [7:0] e_cnt = 8'd0;
  int         age = 0;
  bit         fired = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      hist = '{1'b0, 1'b0};
      run = 0; e_level = 0; e_press = 0; e_rel = 0; e_long = 0;
      e_cnt = 8'd0; age = 0; fired = 0;
      exp_q.delete();
    end else begin
      m_raw = hist.pop_front();
      hist.push_back(btn_in == PIN_DN);
      e_press = 0; e_rel = 0; e_long = 0;
      if (LONG_EN && e_level && !fired) begin
        age++;
        if (age == LONG - 1) begin
          e_long = 1; fired = 1;
        end
      end
      if (m_raw != e_level) run++;
      else run = 0;
      if (run == DEB + 1) begin
        e_level = m_raw; run = 0; age = 0; fired = 0;
        if (m_raw) begin
          e_press = 1; e_cnt++;
          exp_q.push_back(e_cnt);
        end else begin
          e_rel = 1;
        end
      end
    end
  end

  logic [11:0] obs_vec;
  logic [11:0] exp_vec;
  assign obs_vec = {btn_level, press_pulse, release_pulse, long_pulse, press_cnt};
  assign exp_vec = {e_level, e_press, e_rel, e_long, e_cnt};

  // ---------------- scoreboard: count carried by each press pulse ----------------
  logic [7:0] sb_exp;
  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_press unexpected press_pulse, press_cnt=%0d, no press predicted", press_cnt);
      end else begin
        sb_exp = exp_q.pop_front();
        if (press_cnt !== sb_exp) begin
          errors++;
          $display("FAIL sb_press press_cnt=%0d expected %0d", press_cnt, sb_exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic pin);
    btn_in = pin;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    btn_in = PIN_UP;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_vec !== 12'h000) begin
      errors++;
      $display("FAIL reset_state obs=%h expected %h", obs_vec, 12'h000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(PIN_UP);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL idle obs=%h expected %h", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_press_latency();
    int seen = -1;
    int npress = 0;
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(PIN_DN);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL press_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
      end
      if (press_pulse === 1'b1) begin
        npress++;
        if (seen < 0) seen = i;
      end
    end
    checks++;
    if (seen !== DEB + 3) begin
      errors++;
      $display("FAIL press_latency pulse at cycle %0d expected %0d", seen, DEB + 3);
    end
    checks++;
    if (npress !== 1) begin
      errors++;
      $display("FAIL press_once pulses=%0d expected 1", npress);
    end
    checks++;
    if (btn_level !== 1'b1 || press_cnt !== 8'd1) begin
      errors++;
      $display("FAIL press_state level=%b cnt=%0d expected level=1 cnt=1", btn_level, press_cnt);
    end
  endtask

  task automatic test_glitch();
    int npress = 0;
    logic pin;
    // Release first, then: 3-cycle glitch, DEB-cycle glitch (rejected on
    // the final pending cycle), then DEB+1 cycles (shortest accepted press).
    for (int i = 0; i < 12; i++) begin
      drive_cycle(PIN_UP);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL glitch_pre obs=%h expected %h", obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 15 + DEB + 12; i++) begin
      pin = (i < 3 || (i >= 15 && i < 15 + DEB)) ? PIN_DN : PIN_UP;
      drive_cycle(pin);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
      end
      if (press_pulse === 1'b1) npress++;
    end
    checks++;
    if (npress !== 0 || btn_level !== 1'b0 || press_cnt !== 8'd1) begin
      errors++;
      $display("FAIL glitch_reject pulses=%0d level=%b cnt=%0d expected 0/0/1", npress, btn_level, press_cnt);
    end
    for (int i = 0; i < DEB + 1 + 12; i++) begin
      drive_cycle((i < DEB + 1) ? PIN_DN : PIN_UP);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL min_press_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (press_cnt !== 8'd2) begin
      errors++;
      $display("FAIL min_press cnt=%0d expected 2", press_cnt);
    end
  endtask

  task automatic test_release();
    int seen = -1;
    int nrel = 0;
    int npress = 0;
    for (int i = 0; i < 10; i++) drive_cycle(PIN_DN);
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(PIN_UP);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL release_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
      end
      if (release_pulse === 1'b1 && seen < 0) seen = i;
    end
    checks++;
    if (seen !== DEB + 3 || btn_level !== 1'b0) begin
      errors++;
      $display("FAIL release_latency pulse at %0d level=%b expected %0d level=0", seen, btn_level, DEB + 3);
    end
    // Press again, then release with a 2-cycle bounce back to pressed.
    for (int i = 0; i < 10; i++) drive_cycle(PIN_DN);
    for (int i = 0; i < 18; i++) begin
      drive_cycle((i == 2 || i == 3) ? PIN_DN : PIN_UP);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL bounce_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
      end
      if (release_pulse === 1'b1) nrel++;
      if (press_pulse === 1'b1) npress++;
    end
    checks++;
    if (nrel !== 1 || npress !== 0) begin
      errors++;
      $display("FAIL bounce_pulses release=%0d press=%0d expected 1/0", nrel, npress);
    end
  endtask

  task automatic test_long();
    int press_at = -1;
    int long_at = -1;
    int nlong = 0;
    int exp_long;
    logic pin;
    exp_long = LONG_EN ? 1 : 0;
    // Hold 50 cycles, a 2-cycle bounce, then 10 more held cycles.
    for (int i = 1; i <= 62; i++) begin
      pin = (i == 51 || i == 52) ? PIN_UP : PIN_DN;
      drive_cycle(pin);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL long_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
      end
      if (press_pulse === 1'b1 && press_at < 0) press_at = i;
      if (long_pulse === 1'b1) begin
        nlong++;
        if (long_at < 0) long_at = i;
      end
    end
    checks++;
    if (nlong !== exp_long) begin
      errors++;
      $display("FAIL long_count pulses=%0d expected %0d", nlong, exp_long);
    end
`ifdef BTN_LONG_PRESS_EN
    checks++;
    if (long_at - press_at !== LONG - 1) begin
      errors++;
      $display("FAIL long_gap gap=%0d expected %0d", long_at - press_at, LONG - 1);
    end
`endif
    for (int i = 0; i < 12; i++) drive_cycle(PIN_UP);
    // Bounce before the long press matures must not restart the hold count.
    press_at = -1; long_at = -1; nlong = 0;
    for (int i = 1; i <= 45; i++) begin
      pin = (i == 12 || i == 13) ? PIN_UP : PIN_DN;
      drive_cycle(pin);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL long_bounce_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
      end
      if (press_pulse === 1'b1 && press_at < 0) press_at = i;
      if (long_pulse === 1'b1) begin
        nlong++;
        if (long_at < 0) long_at = i;
      end
    end
    checks++;
    if (nlong !== exp_long) begin
      errors++;
      $display("FAIL long_bounce_count pulses=%0d expected %0d", nlong, exp_long);
    end
`ifdef BTN_LONG_PRESS_EN
    checks++;
    if (long_at - press_at !== LONG - 1) begin
      errors++;
      $display("FAIL long_bounce_gap gap=%0d expected %0d", long_at - press_at, LONG - 1);
    end
`endif
    for (int i = 0; i < 12; i++) drive_cycle(PIN_UP);
  endtask

  task automatic test_reset_mid();
    int seen;
    // Reset while pending, then reset while pressed; key stays held.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < ((r == 0) ? 4 : 0); i++) drive_cycle(PIN_DN);
      rst_n = 1'b0;
      drive_cycle(PIN_DN);
      checks++;
      if (obs_vec !== 12'h000) begin
        errors++;
        $display("FAIL reset_mid_%0d obs=%h expected %h", r, obs_vec, 12'h000);
      end
      rst_n = 1'b1;
      seen = -1;
      for (int i = 1; i <= 12; i++) begin
        drive_cycle(PIN_DN);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL reset_mid_model cyc=%0d obs=%h expected %h", i, obs_vec, exp_vec);
        end
        if (press_pulse === 1'b1 && seen < 0) seen = i;
      end
      checks++;
      if (seen !== DEB + 3 || press_cnt !== 8'd1) begin
        errors++;
        $display("FAIL reset_held_press_%0d pulse at %0d cnt=%0d expected %0d cnt=1", r, seen, press_cnt, DEB + 3);
      end
    end
    for (int i = 0; i < 12; i++) drive_cycle(PIN_UP);
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    drive_cycle(PIN_UP);
    rst_n = 1'b1;
    for (int p = 1; p <= 257; p++) begin
      for (int i = 0; i < 2 * (DEB + 3); i++) begin
        drive_cycle((i < DEB + 3) ? PIN_DN : PIN_UP);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL wrap_model press=%0d obs=%h expected %h", p, obs_vec, exp_vec);
        end
      end
      if (p == 256) begin
        checks++;
        if (press_cnt !== 8'd0) begin
          errors++;
          $display("FAIL wrap_256 cnt=%0d expected 0", press_cnt);
        end
      end
    end
    checks++;
    if (press_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wrap_257 cnt=%0d expected 1", press_cnt);
    end
  endtask

  task automatic test_random();
    logic pin;
    int   len;
    for (int seg = 0; seg < 300; seg++) begin
      pin = $urandom_range(0, 1) ? PIN_DN : PIN_UP;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, DEB + 3);
      rst_n = ($urandom_range(0, 39) != 0);
      for (int k = 0; k < len; k++) begin
        drive_cycle(pin);
        rst_n = 1'b1;
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL random_model seg=%0d obs=%h expected %h", seg, obs_vec, exp_vec);
        end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    btn_in = PIN_UP;
    test_reset();
    test_press_latency();
    test_glitch();
    test_release();
    test_long();
    test_reset_mid();
    test_wrap();
    test_random();
    drive_cycle(btn_in);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
